clk_divider_prog: RTL



---
 rtl/clk_divider_prog_if.sv | 40 ++++
 rtl/clk_divider_prog.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/clk_divider_prog_if.sv
// ---------------------------------------------------------------------------
// clk_divider_prog_if
//   Control/status bundle for the multi-channel programmable clock divider.
//   Channel i of div_in/duty_in occupies bits [i*CNT_W +: CNT_W].
//
//   en       per-channel run enable (level)
//   load     per-channel strobe capturing div_in/duty_in into the shadow regs
//   div_in   packed divisors D
//   duty_in  packed high-cycle counts H
//   sync     global phase restart of all enabled channels
//   clk_out  divided clock level per channel
//   tick     one-cycle pulse on the first cycle of every period
//   pending  shadow value waiting to be applied
//
//   master: the controlling side (CPU glue / testbench)
//   slave : the divider itself
// ---------------------------------------------------------------------------
interface clk_divider_prog_if #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 16
);
  logic [CHANNELS-1:0]       en;
  logic [CHANNELS-1:0]       load;
  logic [CHANNELS*CNT_W-1:0] div_in;
  logic [CHANNELS*CNT_W-1:0] duty_in;
  logic                      sync;
  logic [CHANNELS-1:0]       clk_out;
  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS-1:0]       pending;

  modport master (
    output en, load, div_in, duty_in, sync,
    input  clk_out, tick, pending
  );

  modport slave (
    input  en, load, div_in, duty_in, sync,
    output clk_out, tick, pending
  );
endinterface

// File: rtl/clk_divider_prog.sv
// ---------------------------------------------------------------------------
// clk_divider_prog
//   Multi-channel programmable divided-clock / tick generator. Each channel
//   has an active divisor/duty pair used by the running counter and a shadow
//   pair written by load. The shadow is only moved into the active pair at a
//   period boundary (START/WRAP) or while the channel is idle, so a running
//   channel never changes shape mid-period. All outputs are registered.
//
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    clk_divider_prog_if.slave (en, load, div_in, duty_in, sync in;
//          clk_out, tick, pending out)
// ---------------------------------------------------------------------------
module clk_divider_prog #(
  parameter int CHANNELS    = 2,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  clk_divider_prog_if.slave    bus
);

  localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

  logic [CHANNELS-1:0] clk_out_w;
  logic [CHANNELS-1:0] tick_w;
  logic [CHANNELS-1:0] pending_w;

  assign bus.clk_out = clk_out_w;
  assign bus.tick    = tick_w;
  assign bus.pending = pending_w;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_div_q, act_div_d;
    logic [CNT_W-1:0] act_duty_q, act_duty_d;
    logic [CNT_W-1:0] shd_div_q, shd_div_d;
    logic [CNT_W-1:0] shd_duty_q, shd_duty_d;
    logic             run_q, run_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] d_eff, h_eff;
    logic             apply;

    // Clamped view of the active values; H_eff is always >= 1 so the first
    // cycle of every period drives clk_out high.
    always_comb begin
      d_eff = (act_div_q < TWO) ? TWO : act_div_q;
      if (act_duty_q == '0) begin
        h_eff = d_eff >> 1;
      end else if (act_duty_q >= d_eff) begin
        h_eff = d_eff - ONE;
      end else begin
        h_eff = act_duty_q;
      end
    end

    always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      cnt_d      = cnt_q;
      run_d      = run_q;
      clk_out_d  = clk_out_q;
      tick_d     = tick_q;
      apply      = 1'b0;
      act_div_d  = act_div_q;
      act_duty_d = act_duty_q;
      shd_div_d  = shd_div_q;
      shd_duty_d = shd_duty_q;
      pending_d  = pending_q;

      if (!bus.en[i]) begin
        // Idle: outputs low, pending shadow applied immediately.
        cnt_d     = '0;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
        run_d     = 1'b0;
        apply     = pending_q;
      end else if (!run_q || bus.sync || (cnt_q == d_eff - ONE)) begin
        // START (first enabled cycle or sync) and WRAP share one action.
        cnt_d     = '0;
        clk_out_d = 1'b1;
        tick_d    = 1'b1;
        run_d     = 1'b1;
        apply     = pending_q;
      end else begin
        cnt_d     = cnt_q + ONE;
        tick_d    = 1'b0;
        clk_out_d = (cnt_d < h_eff);
      end

      if (apply) begin
        act_div_d  = shd_div_q;
        act_duty_d = shd_duty_q;
        pending_d  = 1'b0;
      end

      // A load on an apply edge lands in the shadow after the old shadow has
      // been consumed, so it stays pending until the next boundary.
      if (bus.load[i]) begin
        shd_div_d  = bus.div_in[i*CNT_W +: CNT_W];
        shd_duty_d = bus.duty_in[i*CNT_W +: CNT_W];
        pending_d  = 1'b1;
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q      <= '0;
        run_q      <= 1'b0;
        clk_out_q  <= 1'b0;
        tick_q     <= 1'b0;
        pending_q  <= 1'b0;
        act_div_q  <= DEF_D;
        act_duty_q <= '0;
        shd_div_q  <= DEF_D;
        shd_duty_q <= '0;
      end else begin
        cnt_q      <= cnt_d;
        run_q      <= run_d;
        clk_out_q  <= clk_out_d;
        tick_q     <= tick_d;
        pending_q  <= pending_d;
        act_div_q  <= act_div_d;
        act_duty_q <= act_duty_d;
        shd_div_q  <= shd_div_d;
        shd_duty_q <= shd_duty_d;
      end
    end

    assign clk_out_w[i] = clk_out_q;
    assign tick_w[i]    = tick_q;
    assign pending_w[i] = pending_q;
  end

endmodule
